// File: rtl/dmem_access_ctrl_pkg.sv
// rtl/dmem_access_ctrl_pkg.sv - shared types and constants for the memory-request stage
package dmem_access_ctrl_pkg;

  localparam int DMEM_DATA_W  = 32;
  localparam int DMEM_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - sequences EX/MR memory ops onto a valid/ready data memory
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DMEM_TIMEOUT,
  parameter int DATA_W  = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              branch_in,
  input  logic              zero_in,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [DATA_W-1:0] branch_target_in,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ready,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata_out,
  output logic              rdata_valid,
  output logic              pc_src,
  output logic [DATA_W-1:0] pc_target,
  output logic              flush,
  output logic              misalign_err,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              terr_q, terr_d;
  logic              load_ok_q, load_ok_d;
  logic              mis_q, mis_d;

  logic access;
  logic aligned;
  logic cnt_last;

  assign access   = mem_read_in | mem_write_in;
  assign aligned  = (addr_in[1:0] == 2'b00);
  assign cnt_last = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: misaligned accesses skip the memory and go straight to DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (access) state_d = aligned ? REQ : DONE;
      REQ:  if (dm_ready || cnt_last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: latch the request, count wait cycles, capture load data
  always_comb begin
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    terr_d    = terr_q;
    load_ok_d = 1'b0;
    mis_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            addr_d  = addr_in;
            wdata_d = wdata_in;
            we_d    = mem_write_in;
            cnt_d   = '0;
          end else begin
            mis_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (dm_ready) begin
          if (!we_q) begin
            rdata_d   = dm_rdata;
            load_ok_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_last) begin
            terr_d  = 1'b1;
            rdata_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      terr_q    <= 1'b0;
      load_ok_q <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      terr_q    <= terr_d;
      load_ok_q <= load_ok_d;
      mis_q     <= mis_d;
    end
  end

  // Outputs: branches resolve only when idle with no memory op in EX/MR
  always_comb begin
    dm_req       = 1'b0;
    stall        = 1'b0;
    pc_src       = 1'b0;
    flush        = 1'b0;
    rdata_valid  = 1'b0;
    misalign_err = 1'b0;
    case (state_q)
      IDLE: begin
        stall  = access;
        pc_src = ~access & branch_in & zero_in;
        flush  = ~access & branch_in & zero_in;
      end
      REQ: begin
        dm_req = 1'b1;
        stall  = 1'b1;
      end
      DONE: begin
        rdata_valid  = load_ok_q;
        misalign_err = mis_q;
      end
      default: ;
    endcase
  end

  assign dm_we       = we_q;
  assign dm_addr     = addr_q;
  assign dm_wdata    = wdata_q;
  assign rdata_out   = rdata_q;
  assign timeout_err = terr_q;
  assign pc_target   = branch_target_in;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_in, mem_write_in, branch_in, zero_in;
  logic [31:0] addr_in, wdata_in, branch_target_in;
  logic        dm_req, dm_we, dm_ready;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        stall, rdata_valid, pc_src, flush, misalign_err, timeout_err;
  logic [31:0] rdata_out, pc_target;

  dmem_access_ctrl #(.TIMEOUT(TO), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .branch_in(branch_in), .zero_in(zero_in),
    .addr_in(addr_in), .wdata_in(wdata_in), .branch_target_in(branch_target_in),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .stall(stall), .rdata_out(rdata_out), .rdata_valid(rdata_valid),
    .pc_src(pc_src), .pc_target(pc_target), .flush(flush),
    .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rd, wr, br, z, rdy;
    logic [31:0] addr, wdata, tgt, rdata;
  } stim_t;

  typedef struct {
    logic        stall, req, we, rvalid, pcs, mis, terr, chkz;
    logic [31:0] addr, wdata, rdata, tgt;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_stall = 0, n_req = 0, n_mis = 0, n_rvalid = 0;

  // Transaction-level reference state: last delivered load data and sticky timeout
  logic [31:0] m_rdata = 32'h0;
  logic        m_terr  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%08h expected=0x%08h", name, cyc, act, exp_v);
    end
  endtask

  function automatic stim_t idle_s();
    stim_t s;
    s = '{rst: 1'b0, rd: 1'b0, wr: 1'b0, br: 1'b0, z: 1'b0, rdy: 1'b0,
          addr: 32'h0, wdata: 32'h0, tgt: 32'h0000_0400, rdata: 32'h0};
    return s;
  endfunction

  function automatic exp_t quiet();
    exp_t e;
    e = '{stall: 1'b0, req: 1'b0, we: 1'b0, rvalid: 1'b0, pcs: 1'b0, mis: 1'b0,
          terr: m_terr, chkz: 1'b0, addr: 32'h0, wdata: 32'h0, rdata: m_rdata, tgt: 32'h0};
    return e;
  endfunction

  task automatic apply(input stim_t s);
    reset = s.rst; mem_read_in = s.rd; mem_write_in = s.wr;
    branch_in = s.br; zero_in = s.z; addr_in = s.addr; wdata_in = s.wdata;
    branch_target_in = s.tgt; dm_ready = s.rdy; dm_rdata = s.rdata;
  endtask

  task automatic drive(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    apply(s);
    e.tgt = s.tgt;
    expq.push_back(e);
  endtask

  // One memory instruction held in EX/MR for as long as stall keeps it there.
  // rdy_ever=0 means the memory never answers.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits, input logic rdy_ever,
                           input logic [31:0] rdata, input logic br);
    stim_t s;
    exp_t  e;
    int    n;
    s = idle_s();
    s.rd = rd; s.wr = wr; s.addr = addr; s.wdata = wdata; s.br = br; s.z = br;
    s.tgt = 32'h0000_1000 + addr;
    e = quiet(); e.stall = 1'b1;
    drive(s, e);
    if (addr[1:0] != 2'b00) begin
      e = quiet(); e.mis = 1'b1;
      drive(s, e);
    end else begin
      n = rdy_ever ? waits + 1 : TO;
      for (int k = 0; k < n; k++) begin
        s.rdy   = rdy_ever && (k == waits);
        s.rdata = s.rdy ? rdata : $urandom;
        e = quiet(); e.stall = 1'b1; e.req = 1'b1; e.we = wr; e.addr = addr; e.wdata = wdata;
        drive(s, e);
      end
      if (rdy_ever && !wr) m_rdata = rdata;
      if (!rdy_ever) begin
        m_terr  = 1'b1;
        m_rdata = 32'h0;
      end
      s.rdy = 1'b1;
      s.rdata = $urandom;
      e = quiet(); e.rvalid = rdy_ever && !wr;
      drive(s, e);
    end
    drive(idle_s(), quiet());
  endtask

  task automatic clear_counts();
    n_stall = 0; n_req = 0; n_mis = 0; n_rvalid = 0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Compare every cycle that has an expectation queued
  always @(negedge clk) begin : cmp_proc
    exp_t e;
    cyc++;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("stall", 32'(stall), 32'(e.stall));
      chk("dm_req", 32'(dm_req), 32'(e.req));
      chk("rdata_valid", 32'(rdata_valid), 32'(e.rvalid));
      chk("pc_src", 32'(pc_src), 32'(e.pcs));
      chk("flush", 32'(flush), 32'(e.pcs));
      chk("misalign_err", 32'(misalign_err), 32'(e.mis));
      chk("timeout_err", 32'(timeout_err), 32'(e.terr));
      chk("rdata_out", rdata_out, e.rdata);
      chk("pc_target", pc_target, e.tgt);
      if (e.req) begin
        chk("dm_we", 32'(dm_we), 32'(e.we));
        chk("dm_addr", dm_addr, e.addr);
        chk("dm_wdata", dm_wdata, e.wdata);
      end
      if (e.chkz) begin
        chk("dm_we_rst", 32'(dm_we), 32'h0);
        chk("dm_addr_rst", dm_addr, 32'h0);
        chk("dm_wdata_rst", dm_wdata, 32'h0);
      end
    end
    if (stall === 1'b1) n_stall++;
    if (dm_req === 1'b1) n_req++;
    if (misalign_err === 1'b1) n_mis++;
    if (rdata_valid === 1'b1) n_rvalid++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main_proc
    stim_t s;
    exp_t  e;
    s = idle_s(); s.rst = 1'b1;
    apply(s);

    // Reset state
    e = quiet(); e.chkz = 1'b1;
    drive(s, e);
    drive(s, e);
    drive(idle_s(), e);

    // Taken branch with no access resolves in the same cycle
    s = idle_s(); s.br = 1'b1; s.z = 1'b1; s.tgt = 32'hDEAD_BEE0;
    e = quiet(); e.pcs = 1'b1;
    drive(s, e);
    s.z = 1'b0;
    drive(s, quiet());
    drive(idle_s(), quiet());

    // Load, ready in the first REQ cycle
    settle(); clear_counts();
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 0, 1'b1, 32'hCAFE_F00D, 1'b0);
    settle();
    chk("load_stall_cycles", n_stall, 2);
    chk("load_req_cycles", n_req, 1);
    chk("load_rvalid_pulses", n_rvalid, 1);
    chk("load_rdata_lit", rdata_out, 32'hCAFE_F00D);

    // Store with three wait cycles
    clear_counts();
    do_access(1'b0, 1'b1, 32'h20, 32'h1234_5678, 3, 1'b1, 32'h5555_AAAA, 1'b0);
    settle();
    chk("store_stall_cycles", n_stall, 5);
    chk("store_req_cycles", n_req, 4);
    chk("store_rvalid_pulses", n_rvalid, 0);

    // Read and write both set: write wins
    do_access(1'b1, 1'b1, 32'h24, 32'hA5A5_0F0F, 1, 1'b1, 32'h7777_7777, 1'b0);

    // Branch while a load is outstanding is not taken
    do_access(1'b1, 1'b0, 32'h30, 32'h0, 2, 1'b1, 32'h0102_0304, 1'b1);

    // Misaligned load
    settle(); clear_counts();
    do_access(1'b1, 1'b0, 32'h13, 32'h0, 0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    settle();
    chk("mis_stall_cycles", n_stall, 1);
    chk("mis_req_cycles", n_req, 0);
    chk("mis_pulses", n_mis, 1);

    // Memory never answers
    clear_counts();
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 0, 1'b0, 32'h0, 1'b0);
    settle();
    chk("to_req_cycles", n_req, 15);
    chk("to_stall_cycles", n_stall, 16);
    chk("to_sticky_lit", 32'(timeout_err), 32'h1);
    chk("to_rdata_lit", rdata_out, 32'h0);

    // Later load still completes; timeout_err stays set
    do_access(1'b1, 1'b0, 32'h44, 32'h0, 1, 1'b1, 32'h1357_9BDF, 1'b0);

    // Reset while a request is outstanding
    s = idle_s(); s.rd = 1'b1; s.addr = 32'h50;
    e = quiet(); e.stall = 1'b1;
    drive(s, e);
    e.req = 1'b1; e.addr = 32'h50;
    drive(s, e);
    s.rst = 1'b1;
    drive(s, e);
    m_rdata = 32'h0;
    m_terr  = 1'b0;
    s = idle_s(); s.rst = 1'b1;
    e = quiet(); e.chkz = 1'b1;
    drive(s, e);
    drive(idle_s(), e);
    do_access(1'b1, 1'b0, 32'h60, 32'h0, 0, 1'b1, 32'h0BAD_F00D, 1'b0);
    settle();
    chk("post_reset_terr_lit", 32'(timeout_err), 32'h0);
    chk("post_reset_rdata_lit", rdata_out, 32'h0BAD_F00D);
    chk("queue_drained", 32'(expq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
